// File: rtl/pic_8259a_pkg.sv
// Shared definitions for the 8259A acknowledge sequencer.
// Holds state encoding, IR width and the lowest-set-bit helper.
package pic_8259a_pkg;

    localparam int IR_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK1 = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_ACK2 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ACK1 = ST_ACK1,
        GAP  = ST_GAP,
        ACK2 = ST_ACK2
    } seq_state_e;

    // IR0 is highest priority, so the lowest set index wins.
    function automatic logic [2:0] lowest_set(
        input logic [IR_WIDTH-1:0] v
    );
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = IR_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[2:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/interrupt_acknowledge_sequencer_8259a_if.sv
// Request, control and vector bus between the 8259A request register,
// the acknowledge sequencer and the CPU-side bus interface.
interface interrupt_acknowledge_sequencer_8259a_if;
    import pic_8259a_pkg::*;

    logic [IR_WIDTH-1:0] interrupt_request_register;
    logic [IR_WIDTH-1:0] interrupt_mask;
    logic [4:0]          vector_base;
    logic                auto_eoi_config;
    logic                end_of_interrupt;
    logic                interrupt_acknowledge_n;
    logic                interrupt_to_cpu;
    logic                freeze;
    logic [IR_WIDTH-1:0] clear_interrupt_request;
    logic [IR_WIDTH-1:0] in_service_register;
    logic [7:0]          data_bus_out;
    logic                data_bus_out_enable;

    modport master (
        input  interrupt_request_register,
        input  interrupt_mask,
        input  vector_base,
        input  auto_eoi_config,
        input  end_of_interrupt,
        input  interrupt_acknowledge_n,
        output interrupt_to_cpu,
        output freeze,
        output clear_interrupt_request,
        output in_service_register,
        output data_bus_out,
        output data_bus_out_enable
    );

    modport slave (
        output interrupt_request_register,
        output interrupt_mask,
        output vector_base,
        output auto_eoi_config,
        output end_of_interrupt,
        output interrupt_acknowledge_n,
        input  interrupt_to_cpu,
        input  freeze,
        input  clear_interrupt_request,
        input  in_service_register,
        input  data_bus_out,
        input  data_bus_out_enable
    );

endinterface

// File: rtl/priority_resolver_8259a.sv
// Fixed-priority resolver: picks the highest-priority pending request
// that outranks the highest-priority in-service level.
module priority_resolver_8259a
    import pic_8259a_pkg::*;
(
    input  logic [IR_WIDTH-1:0] pending,
    input  logic [IR_WIDTH-1:0] isr,
    output logic                valid,
    output logic [2:0]          level
);

    logic [2:0] pend_lvl;
    logic [2:0] isr_lvl;
    logic       isr_any;

    assign pend_lvl = lowest_set(pending);
    assign isr_lvl  = lowest_set(isr);
    assign isr_any  = |isr;

    assign valid = (|pending) && (!isr_any || (pend_lvl < isr_lvl));
    assign level = pend_lvl;

endmodule

// File: rtl/interrupt_acknowledge_sequencer_8259a.sv
// 8086-mode INTA sequencer: raises INT, runs the two-pulse acknowledge,
// owns the ISR and places the vector on the internal data bus.
module interrupt_acknowledge_sequencer_8259a
    import pic_8259a_pkg::*;
#(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input logic clock,
    input logic reset_n,
    interrupt_acknowledge_sequencer_8259a_if.master bus
);

    seq_state_e          state_q;
    seq_state_e          state_d;
    logic                inta_q;
    logic                int_q;
    logic                int_d;
    logic                freeze_q;
    logic                freeze_d;
    logic [IR_WIDTH-1:0] clear_q;
    logic [IR_WIDTH-1:0] clear_d;
    logic [IR_WIDTH-1:0] isr_q;
    logic [IR_WIDTH-1:0] isr_d;
    logic [2:0]          level_q;
    logic [2:0]          level_d;
    logic                spur_q;
    logic                spur_d;
    logic [7:0]          dbo_q;
    logic [7:0]          dbo_d;
    logic                dbe_q;
    logic                dbe_d;

    logic [IR_WIDTH-1:0] pending;
    logic                win_valid;
    logic [2:0]          win_level;
    logic                fall;
    logic                rise;

    assign pending = bus.interrupt_request_register & ~bus.interrupt_mask;
    assign fall    = inta_q & ~bus.interrupt_acknowledge_n;
    assign rise    = ~inta_q & bus.interrupt_acknowledge_n;

    priority_resolver_8259a u_resolver (
        .pending (pending),
        .isr     (isr_q),
        .valid   (win_valid),
        .level   (win_level)
    );

    always_comb begin
        state_d  = state_q;
        int_d    = 1'b0;
        freeze_d = freeze_q;
        clear_d  = '0;
        isr_d    = isr_q;
        level_d  = level_q;
        spur_d   = spur_q;
        dbo_d    = dbo_q;
        dbe_d    = dbe_q;

        // EOI works on the ISR as it stood before any same-cycle set.
        if (bus.end_of_interrupt && (|isr_q)) begin
            isr_d[lowest_set(isr_q)] = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                int_d = win_valid & ~fall;
                if (fall) begin
                    state_d  = ACK1;
                    freeze_d = 1'b1;
                    if (win_valid) begin
                        isr_d[win_level]   = 1'b1;
                        clear_d[win_level] = 1'b1;
                        level_d            = win_level;
                        spur_d             = 1'b0;
                    end else begin
                        level_d = SPURIOUS_LEVEL;
                        spur_d  = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (rise) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (fall) begin
                    state_d = ACK2;
                    dbo_d   = {bus.vector_base, level_q};
                    dbe_d   = 1'b1;
                end
            end
            ACK2: begin
                if (rise) begin
                    state_d  = IDLE;
                    dbe_d    = 1'b0;
                    freeze_d = 1'b0;
                    if (bus.auto_eoi_config && !spur_q) begin
                        isr_d[level_q] = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            inta_q   <= 1'b1;
            int_q    <= 1'b0;
            freeze_q <= 1'b0;
            clear_q  <= '0;
            isr_q    <= '0;
            level_q  <= 3'd0;
            spur_q   <= 1'b0;
            dbo_q    <= 8'h00;
            dbe_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            inta_q   <= bus.interrupt_acknowledge_n;
            int_q    <= int_d;
            freeze_q <= freeze_d;
            clear_q  <= clear_d;
            isr_q    <= isr_d;
            level_q  <= level_d;
            spur_q   <= spur_d;
            dbo_q    <= dbo_d;
            dbe_q    <= dbe_d;
        end
    end

    assign bus.interrupt_to_cpu        = int_q;
    assign bus.freeze                  = freeze_q;
    assign bus.clear_interrupt_request = clear_q;
    assign bus.in_service_register     = isr_q;
    assign bus.data_bus_out            = dbo_q;
    assign bus.data_bus_out_enable     = dbe_q;

endmodule
